mux_select_sequencer: RTL and testbench

Drives the one-hot row and column select lines of the 2x2 bolometer mux matrix from the binary row/column indices produced by the row and column counters. For each requested pixel it applies a break-before-make dead time and then an analog settle interval. It then requests one ADC conversion and reports completion with a one-cycle pulse, which the top level uses to advance the counters.

---
 rtl/mux_select_sequencer_pkg.sv | 19 +
 rtl/mux_select_sequencer_onehot_decoder.sv | 20 ++
 rtl/mux_select_sequencer.sv | 159 +++++++++++++++
 tb/tb_mux_select_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_select_sequencer_pkg.sv
// rtl/mux_select_sequencer_pkg.sv - shared state encoding and timing defaults for the mux select sequencer
package mux_select_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BREAK  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEFAULT_DEAD_CYCLES   = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 50;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_onehot_decoder.sv
// rtl/mux_select_sequencer_onehot_decoder.sv - binary index to one-hot select with in-range flag
module mux_select_sequencer_onehot_decoder #(
  parameter int Width = 5,
  parameter int N     = 2
) (
  input  logic [Width-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             in_range
);

  // An index beyond N-1 decodes to all zeros, so the flag is just the OR of the lines.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (idx == Width'(i));
    end
    in_range = |onehot;
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - break-before-make row/column select sequencing with settle and ADC handshake
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int Width        = 5,
  parameter int Rows         = 2,
  parameter int Cols         = 2,
  parameter int DeadCycles   = DEFAULT_DEAD_CYCLES,
  parameter int SettleCycles = DEFAULT_SETTLE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] row_i,
  input  logic [Width-1:0] col_i,
  input  logic             ack_i,
  output logic [Rows-1:0]  row_sel_o,
  output logic [Cols-1:0]  col_sel_o,
  output logic             sample_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CntW = $clog2(max_int(DeadCycles, SettleCycles) + 1);
  localparam logic [CntW-1:0] DeadLast   = CntW'(DeadCycles - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Requested pixel, held in one-hot form from acceptance until the next accepted start.
  logic [Rows-1:0] row_lat_q, row_lat_d;
  logic [Cols-1:0] col_lat_q, col_lat_d;

  logic [Rows-1:0] row_sel_q, row_sel_d;
  logic [Cols-1:0] col_sel_q, col_sel_d;
  logic            sample_q, sample_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [Rows-1:0] row_dec;
  logic [Cols-1:0] col_dec;
  logic            row_ok, col_ok;

  mux_select_sequencer_onehot_decoder #(.Width(Width), .N(Rows)) u_row_dec (
    .idx      (row_i),
    .onehot   (row_dec),
    .in_range (row_ok)
  );

  mux_select_sequencer_onehot_decoder #(.Width(Width), .N(Cols)) u_col_dec (
    .idx      (col_i),
    .onehot   (col_dec),
    .in_range (col_ok)
  );

  // Next state plus next output values; outputs are derived from the next state so the registered copies track the state register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_lat_d = row_lat_q;
    col_lat_d = col_lat_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (row_ok && col_ok) begin
            row_lat_d = row_dec;
            col_lat_d = col_dec;
            cnt_d     = '0;
            state_d   = ST_BREAK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (cnt_q == DeadLast) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_SAMPLE: begin
        if (ack_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Selects drop for the dead time, then show the new pixel and hold it through IDLE.
    row_sel_d = row_sel_q;
    col_sel_d = col_sel_q;
    if (state_d == ST_BREAK) begin
      row_sel_d = '0;
      col_sel_d = '0;
    end else if (state_d == ST_SETTLE) begin
      row_sel_d = row_lat_d;
      col_sel_d = col_lat_d;
    end

    sample_d = (state_d == ST_SAMPLE);
    done_d   = (state_d == ST_DONE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter, latched pixel and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_lat_q <= '0;
      col_lat_q <= '0;
      row_sel_q <= '0;
      col_sel_q <= '0;
      sample_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_lat_q <= row_lat_d;
      col_lat_q <= col_lat_d;
      row_sel_q <= row_sel_d;
      col_sel_q <= col_sel_d;
      sample_q  <= sample_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign row_sel_o = row_sel_q;
  assign col_sel_o = col_sel_q;
  assign sample_o  = sample_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - vector table and corner sequences for mux_select_sequencer
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ack;
  logic [4:0] row;
  logic [4:0] col;
  logic [1:0] row_sel;
  logic [1:0] col_sel;
  logic       sample;
  logic       busy;
  logic       done;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_select_sequencer #(
    .Width        (5),
    .Rows         (2),
    .Cols         (2),
    .DeadCycles   (2),
    .SettleCycles (3)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .row_i     (row),
    .col_i     (col),
    .ack_i     (ack),
    .row_sel_o (row_sel),
    .col_sel_o (col_sel),
    .sample_o  (sample),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [4:0] row;
    logic [4:0] col;
    logic       ack;
    logic [1:0] row_sel;
    logic [1:0] col_sel;
    logic       sample;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic [4:0] ri, input logic [4:0] ci,
                              input logic a, input logic [1:0] rs, input logic [1:0] cs,
                              input logic sm, input logic b, input logic d, input logic e);
    vec_t v;
    v.rst = r; v.start = s; v.row = ri; v.col = ci; v.ack = a;
    v.row_sel = rs; v.col_sel = cs; v.sample = sm; v.busy = b; v.done = d; v.err = e;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {row_sel, col_sel, sample, busy, done, err};
  endfunction

  // Pulse start for one cycle and count cycles until done_o (cycle n = n edges after the start edge).
  task automatic launch(input logic [4:0] r, input logic [4:0] c, input int limit, output int lat);
    row = r; col = c; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    for (int i = 2; i <= limit && lat == 0; i++) begin
      step();
      if (done === 1'b1) lat = i;
    end
  endtask

  initial begin
    int lat;
    int rise;
    int hi;
    int first;
    int second;

    rst = 1'b0; start = 1'b0; ack = 1'b0; row = '0; col = '0;

    // Reset held with start high, then release.
    add(0, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0);
    // Normal sequence row=1 col=0, ack tied high.
    add(1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'b01, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'b01, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'b01, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'b01, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'b01, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 2'b10, 2'b01, 0, 0, 0, 0);
    // Out-of-range row, then out-of-range column, selects keep pixel (1,0).
    add(1, 1, 2, 0, 1, 2'b10, 2'b01, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0);
    add(1, 1, 0, 5, 0, 2'b10, 2'b01, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0);
    // Pixel (0,1): ack during BREAK and start during SETTLE are both ignored.
    add(1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b00, 2'b00, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 2'b01, 2'b10, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 2'b01, 2'b10, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 2'b01, 2'b10, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 2'b01, 2'b10, 0, 1, 1, 0);
    add(1, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start = vecs[i].start; row = vecs[i].row;
      col = vecs[i].col; ack = vecs[i].ack;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].row_sel, vecs[i].col_sel, vecs[i].sample,
               vecs[i].busy, vecs[i].done, vecs[i].err}));
    end
    start = 1'b0; ack = 1'b0;

    // Delayed ack: sample_o must stay high exactly 10 cycles, then one done pulse.
    row = 1; col = 1; start = 1'b1;
    step();
    start = 1'b0;
    rise = 0;
    for (int i = 2; i <= 20 && rise == 0; i++) begin
      step();
      if (sample === 1'b1) rise = i;
    end
    chk("sample_rise_cycle", rise, 6);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (sample !== 1'b1) break;
      hi++;
      if (hi == 10) ack = 1'b1;
      step();
    end
    chk("sample_high_cycles", hi, 10);
    chk("delayed_done", {31'd0, done}, 1);
    ack = 1'b0;
    step();
    chk("delayed_done_single", {30'd0, done, busy}, 0);

    // Back-to-back with start held high through DONE.
    ack = 1'b1; row = 0; col = 0; start = 1'b1;
    first = 0; second = 0;
    for (int i = 1; i <= 40 && second == 0; i++) begin
      step();
      if (done === 1'b1) begin
        if (first == 0) first = i;
        else second = i;
      end
    end
    start = 1'b0;
    chk("b2b_first_latency", first, 7);
    chk("b2b_period", second - first, 8);
    step();
    chk("b2b_idle_busy", {31'd0, busy}, 0);

    // Reset during SAMPLE: everything clears, no done, then a fresh start completes.
    ack = 1'b0; row = 1; col = 1; start = 1'b1;
    step();
    start = 1'b0;
    rise = 0;
    for (int i = 2; i <= 20 && rise == 0; i++) begin
      step();
      if (sample === 1'b1) rise = i;
    end
    chk("rst_pre_sample", rise, 6);
    rst = 1'b0; ack = 1'b1;
    step();
    chk("rst_mid_outputs", 32'(outs()), 0);
    rst = 1'b1;
    step();
    chk("rst_post_idle", 32'(outs()), 0);
    launch(5'd0, 5'd1, 20, lat);
    chk("fresh_latency", lat, 7);
    chk("fresh_selects", {28'd0, row_sel, col_sel}, 32'b0110);
    ack = 1'b0;
    step();
    chk("fresh_busy_low", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
